rotation_cordic_iter: RTL and testbench

Iterative (folded) circular CORDIC in rotation mode. It is the inverse-direction companion to the 16-stage vectoring unit: it takes a vector and an angle and rotates the vector by that angle, so it performs polar-to-rectangular conversion when fed (magnitude, 0, angle). The unit uses one shared micro-rotation datapath for 16 iterations, one per clock, behind a valid/ready handshake. It uses the same 16-bit angle format and arctangent table as the vectoring unit, so one unit's output can feed the other directly.

---
 rtl/cordic_pkg.sv | 36 +++
 rtl/cordic_rot_step.sv | 39 +++
 rtl/rotation_cordic_iter.sv | 109 ++++++++++
 tb/tb_rotation_cordic_iter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and types for the circular CORDIC units (rotation and vectoring).
// Latency: none (package only).
// Backpressure: not applicable.
package cordic_pkg;

    localparam int ITER  = 16;
    localparam int WIDTH = 16;

    // Angle format: full circle maps to 2^16, so 0x8000 is +/-pi.
    localparam logic [15:0] ANGLE_PI      = 16'h8000;
    localparam logic [15:0] ANGLE_HALF_PI = 16'h4000;

    // Uncompensated CORDIC gain K ~= 1.64676 in Q14.
    localparam logic [15:0] K_GAIN_Q14 = 16'h6965;

    // atan(2^-i) in the 16-bit angle format.
    localparam logic [15:0] ATAN_LUT [0:15] = '{
        16'h2000, 16'h12E4, 16'h09FB, 16'h0511,
        16'h028B, 16'h0146, 16'h00A3, 16'h0051,
        16'h0029, 16'h0014, 16'h000A, 16'h0005,
        16'h0003, 16'h0001, 16'h0001, 16'h0000
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Angles in quadrant II or III lie outside the CORDIC convergence range
    // and are folded by a 180 degree pre-rotation.
    function automatic logic pre_rotate_needed(input logic [15:0] z);
        return z[15] ^ z[14];
    endfunction

endpackage

// File: rtl/cordic_rot_step.sv
// One circular micro-rotation: direction from the sign of z, arithmetic shifts by 'shift'.
// Latency: purely combinational.
// Backpressure: none; the caller owns all handshaking.
module cordic_rot_step
    import cordic_pkg::*;
(
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    input  logic [3:0]       shift,
    input  logic [WIDTH-1:0] atan,
    output logic [WIDTH-1:0] x_nxt,
    output logic [WIDTH-1:0] y_nxt,
    output logic [WIDTH-1:0] z_nxt
);

    logic [WIDTH-1:0] x_sh;
    logic [WIDTH-1:0] y_sh;

    assign x_sh = WIDTH'($signed(x) >>> shift);
    assign y_sh = WIDTH'($signed(y) >>> shift);

    // Rotate toward z = 0: positive residual rotates counter-clockwise, negative clockwise.
    always_comb begin
        x_nxt = x;
        y_nxt = y;
        z_nxt = z;
        if (!z[WIDTH-1]) begin
            x_nxt = x - y_sh;
            y_nxt = y + x_sh;
            z_nxt = z - atan;
        end else begin
            x_nxt = x + y_sh;
            y_nxt = y - x_sh;
            z_nxt = z + atan;
        end
    end

endmodule

// File: rtl/rotation_cordic_iter.sv
// Folded rotation-mode CORDIC: rotates (X_i, Y_i) by Z_i using one shared micro-rotation stage.
// Latency: accept at edge N, result valid after edge N+16; 18 cycles per result with out_ready high.
// Backpressure: result held in DONE until out_ready; no new input is accepted until then.
module rotation_cordic_iter
    import cordic_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] X_i,
    input  logic [15:0] Y_i,
    input  logic [15:0] Z_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] X_O,
    output logic [15:0] Y_O,
    output logic [15:0] Z_O
);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  iter;
    logic [15:0] x_r;
    logic [15:0] y_r;
    logic [15:0] z_r;
    logic [15:0] x_s;
    logic [15:0] y_s;
    logic [15:0] z_s;
    logic        accept;
    logic        last_iter;

    // Handshake outputs come straight from the state register.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last_iter = (iter == 4'(ITER - 1));

    cordic_rot_step u_step (
        .x     (x_r),
        .y     (y_r),
        .z     (z_r),
        .shift (iter),
        .atan  (ATAN_LUT[iter]),
        .x_nxt (x_s),
        .y_nxt (y_s),
        .z_nxt (z_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: IDLE -> ROTATE on accept, ROTATE -> DONE after the last step, DONE -> IDLE on out_ready.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = ROTATE;
            ROTATE:  if (last_iter) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Working registers: load pre-rotated operands on accept, then one micro-rotation per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_r  <= '0;
            y_r  <= '0;
            z_r  <= '0;
            iter <= '0;
        end else if (accept) begin
            if (pre_rotate_needed(Z_i)) begin
                x_r <= 16'd0 - X_i;
                y_r <= 16'd0 - Y_i;
                z_r <= Z_i + ANGLE_PI;
            end else begin
                x_r <= X_i;
                y_r <= Y_i;
                z_r <= Z_i;
            end
            iter <= '0;
        end else if (state == ROTATE) begin
            x_r  <= x_s;
            y_r  <= y_s;
            z_r  <= z_s;
            iter <= iter + 4'd1;
        end
    end

    // Output registers capture the final micro-rotation and hold until the next result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            X_O <= '0;
            Y_O <= '0;
            Z_O <= '0;
        end else if ((state == ROTATE) && last_iter) begin
            X_O <= x_s;
            Y_O <= y_s;
            Z_O <= z_s;
        end
    end

endmodule

// File: tb/tb_rotation_cordic_iter.sv
// Self-checking bench for rotation_cordic_iter: scoreboard of bit-exact expected results plus ideal-value tolerance checks.
// Latency: checks 16-edge result latency and 18-cycle throughput.
// Backpressure: exercises held out_ready with in_valid asserted, and asynchronous reset mid-operation.
module tb_rotation_cordic_iter;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] X_i;
    logic [15:0] Y_i;
    logic [15:0] Z_i;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] X_O;
    logic [15:0] Y_O;
    logic [15:0] Z_O;

    int   n_cmp = 0;
    int   n_err = 0;
    res_t sb_q[$];

    logic [15:0] tbl [16] = '{
        16'h2000, 16'h12E4, 16'h09FB, 16'h0511, 16'h028B, 16'h0146, 16'h00A3, 16'h0051,
        16'h0029, 16'h0014, 16'h000A, 16'h0005, 16'h0003, 16'h0001, 16'h0001, 16'h0000
    };

    rotation_cordic_iter dut (
        .clk       (clk),
        .reset     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X_i       (X_i),
        .Y_i       (Y_i),
        .Z_i       (Z_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .X_O       (X_O),
        .Y_O       (Y_O),
        .Z_O       (Z_O)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Returns exp when got is within tol of it, otherwise got unchanged so the report shows the real value.
    function automatic int near(input int got, input int exp, input int tol);
        int d;
        d = got - exp;
        if (d < 0) d = -d;
        return (d <= tol) ? exp : got;
    endfunction

    // Reference rotation-mode CORDIC written straight from the algorithm description.
    function automatic res_t model(input logic [15:0] xi, input logic [15:0] yi, input logic [15:0] zi);
        logic signed [15:0] x, y, xn, yn;
        logic [15:0] z, zn;
        res_t r;
        if (zi[15] ^ zi[14]) begin
            x = -$signed(xi);
            y = -$signed(yi);
            z = zi + 16'h8000;
        end else begin
            x = xi;
            y = yi;
            z = zi;
        end
        for (int i = 0; i < 16; i++) begin
            if (!z[15]) begin
                xn = x - (y >>> i);
                yn = y + (x >>> i);
                zn = z - tbl[i];
            end else begin
                xn = x + (y >>> i);
                yn = y - (x >>> i);
                zn = z + tbl[i];
            end
            x = xn;
            y = yn;
            z = zn;
        end
        r.x = x;
        r.y = y;
        r.z = z;
        return r;
    endfunction

    // Drive one operand set and wait (bounded) for the accepting edge; pushes the expected result.
    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        int waited;
        waited = 0;
        @(negedge clk);
        X_i = x;
        Y_i = y;
        Z_i = z;
        in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk("send_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            sb_q.push_back(model(x, y, z));
            #1;
            in_valid = 1'b0;
            chk("busy_after_accept", int'(in_ready), 0);
        end
    endtask

    // Count edges after the accept until out_valid is seen.
    task automatic wait_out(output int edges);
        edges = 0;
        while (edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (out_valid) break;
        end
    endtask

    // Compare held outputs with the scoreboard head.
    task automatic compare_head(input string tag);
        res_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_x"}, int'($signed(X_O)), int'($signed(e.x)));
            chk({tag, "_y"}, int'($signed(Y_O)), int'($signed(e.y)));
            chk({tag, "_z"}, int'($signed(Z_O)), int'($signed(e.z)));
        end
    endtask

    // Complete the output handshake and confirm the unit is idle afterwards.
    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_rdy_after_hs"}, int'(in_ready), 1);
        chk({tag, "_vld_after_hs"}, int'(out_valid), 0);
        out_ready = 1'b0;
    endtask

    int          xs [5] = '{16384, 16384, 16384, 16384, 16384};
    int          zs [5] = '{32'h0000, 32'h2000, 32'h4000, 32'h8000, 32'hC000};
    int          ix [5] = '{26981, 19079, 0, -26981, 0};
    int          iy [5] = '{0, 19079, 26981, 0, -26981};
    bit          cx [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        int          edges;
        int          rx, ry;
        logic [15:0] hx, hy, hz;
        int          pushes, results;
        int          t_prev, t_cur, cyc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        X_i       = '0;
        Y_i       = '0;
        Z_i       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", int'(X_O), 0);
        chk("rst_y", int'(Y_O), 0);
        chk("rst_z", int'(Z_O), 0);
        chk("rst_vld", int'(out_valid), 0);
        chk("rst_rdy", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed angles: exact scoreboard plus tolerance against ideal K-scaled values.
        for (int k = 0; k < 5; k++) begin
            send(16'(xs[k]), 16'h0000, 16'(zs[k]));
            wait_out(edges);
            chk($sformatf("dir%0d_latency", k), edges, 16);
            if (k == 0) chk("dir0_z_near", near(int'($signed(Z_O)), 0, 4), 0);
            if (cx[k]) chk($sformatf("dir%0d_x_near", k), near(int'($signed(X_O)), ix[k], 4), ix[k]);
            chk($sformatf("dir%0d_y_near", k), near(int'($signed(Y_O)), iy[k], 4), iy[k]);
            compare_head($sformatf("dir%0d", k));
            handshake($sformatf("dir%0d", k));
        end

        // Random in-range vectors and angles.
        for (int k = 0; k < 6; k++) begin
            rx = int'($urandom_range(38000)) - 19000;
            ry = int'($urandom_range(38000)) - 19000;
            send(16'(rx), 16'(ry), 16'($urandom_range(65535)));
            wait_out(edges);
            chk($sformatf("rnd%0d_latency", k), edges, 16);
            compare_head($sformatf("rnd%0d", k));
            handshake($sformatf("rnd%0d", k));
        end

        // Backpressure: result held in DONE while new input is offered.
        send(16'd12000, 16'd3000, 16'h1234);
        wait_out(edges);
        chk("bp_latency", edges, 16);
        hx = X_O;
        hy = Y_O;
        hz = Z_O;
        @(negedge clk);
        X_i       = 16'd5000;
        Y_i       = 16'd7000;
        Z_i       = 16'h2000;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold_x_%0d", c), int'(X_O), int'(hx));
            chk($sformatf("bp_hold_y_%0d", c), int'(Y_O), int'(hy));
            chk($sformatf("bp_hold_z_%0d", c), int'(Z_O), int'(hz));
            chk($sformatf("bp_rdy_%0d", c), int'(in_ready), 0);
            chk($sformatf("bp_vld_%0d", c), int'(out_valid), 1);
        end
        compare_head("bp");
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("bp_rdy_after_hs", int'(in_ready), 1);
        chk("bp_vld_after_hs", int'(out_valid), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_not_taken", int'(in_ready), 1);

        // Reset in the middle of a rotation discards it; a fresh transaction still works.
        send(16'h4000, 16'h0000, 16'h0000);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_x", int'(X_O), 0);
        chk("mid_rst_y", int'(Y_O), 0);
        chk("mid_rst_z", int'(Z_O), 0);
        chk("mid_rst_vld", int'(out_valid), 0);
        chk("mid_rst_rdy", int'(in_ready), 1);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h4000, 16'h0000, 16'h2000);
        wait_out(edges);
        chk("post_rst_latency", edges, 16);
        chk("post_rst_x_near", near(int'($signed(X_O)), 19079, 4), 19079);
        chk("post_rst_y_near", near(int'($signed(Y_O)), 19079, 4), 19079);
        compare_head("post_rst");
        handshake("post_rst");

        // Throughput with in_valid and out_ready held high: one result every 18 cycles.
        pushes  = 0;
        results = 0;
        t_prev  = -1;
        cyc     = 0;
        @(negedge clk);
        X_i       = 16'd9000;
        Y_i       = -16'sd4000;
        Z_i       = 16'hE000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (results < 3 && cyc < 100) begin
            if (pushes == 3) in_valid = 1'b0;
            if (in_valid && in_ready) begin
                sb_q.push_back(model(X_i, Y_i, Z_i));
                pushes++;
            end
            if (out_valid) begin
                t_cur = cyc;
                if (t_prev >= 0) chk($sformatf("thr_period_%0d", results), t_cur - t_prev, 18);
                t_prev = t_cur;
                compare_head($sformatf("thr%0d", results));
                results++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("thr_results", results, 3);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
